ex_mem_reg: RTL and testbench
=============================

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Parameter: n, 64, datapath width of result, store-data and branch-target fields.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Stall  input  1  hold all stored fields for this edge.
REQ-005 Flush  input  1  replace stored entry with a bubble at this edge.
REQ-006 InValid  input  1  EX stage holds a real instruction.
REQ-007 ALUResult  input  n  ALU BusW output (address or arithmetic result).
REQ-008 Zero  input  1  ALU zero flag.
REQ-009 StoreData  input  n  register operand for STUR.
REQ-010 BranchTarget  input  n  computed PC-relative target.
REQ-011 Rd  input  5  destination register index.
REQ-012 RegWrite, MemRead, MemWrite, MemToReg, Branch, UncondBranch  input  1 each  EX-stage control bits.
REQ-013 OutValid  output  1  MEM stage holds a real instruction.
REQ-014 ALUResultOut, StoreDataOut, BranchTargetOut  output  n each  registered data fields.
REQ-015 RdOut  output  5  registered destination index.
REQ-016 RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut  output  1 each  registered controls.
REQ-017 PCSrc  output  1  registered branch-taken decision for the fetch stage.
REQ-018 FwdEn  output  1  MEM-stage result is eligible for forwarding to EX.

Function
REQ-019 All outputs SHALL be registered; latency EX input to output SHALL be exactly one CLK edge.
REQ-020 Edge priority SHALL be Reset > Flush > Stall > capture.
REQ-021 Capture: every data field and Rd SHALL load its input unchanged; OutValid SHALL load InValid.
REQ-022 Capture with InValid=0: RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut, PCSrc SHALL load 0; data fields load inputs.
REQ-023 PCSrc SHALL load InValid & (UncondBranch | (Branch & Zero)).
REQ-024 Flush SHALL load OutValid=0, all control outputs and PCSrc=0, data fields and RdOut=0, regardless of Stall.
REQ-025 Stall (Flush=0) SHALL keep every output, including PCSrc, at its previous value.
REQ-026 FwdEn SHALL be combinational from registered state: OutValid & RegWriteOut & (RdOut != 5'd31).
REQ-027 Rd=31 (XZR) SHALL still be stored and RegWriteOut still passed; only FwdEn is suppressed.
REQ-028 MemReadOut and MemWriteOut both 1 SHALL never be produced from a valid capture unless both inputs are 1; block performs no arbitration.
REQ-029 Zero SHALL be sampled at the rising edge only; glitches between edges SHALL not affect state.

Reset
REQ-030 Reset=1 at an edge SHALL set every output field, OutValid, PCSrc to 0, overriding Flush, Stall and all data inputs.
REQ-031 Reset asserted mid-stall SHALL clear the held entry at the next edge; first capture occurs on the first edge with Reset=0 and Stall=0.
REQ-032 Between power-up and first Reset edge outputs are undefined; bench SHALL apply Reset before checking.

Verification
REQ-033 Reset: Reset=1 one edge with all inputs 1 -> all outputs 0, FwdEn=0.
REQ-034 Capture: InValid=1, ALUResult=64'h0000_0000_0000_00A5, Rd=5, RegWrite=1 -> next edge ALUResultOut=A5, RdOut=5, RegWriteOut=1, FwdEn=1.
REQ-035 Branch: Branch=1, Zero=1, BranchTarget=64'h40 -> PCSrc=1, BranchTargetOut=40; same with Zero=0 -> PCSrc=0; UncondBranch=1, Zero=0 -> PCSrc=1.
REQ-036 Stall/Flush: load ALUResult=64'h10, then Stall=1 two edges with ALUResult=64'h20 -> output stays 10; Stall=1 and Flush=1 together -> OutValid=0, all controls 0.
REQ-037 XZR and invalid: Rd=31, RegWrite=1, InValid=1 -> RegWriteOut=1, FwdEn=0; InValid=0, MemWrite=1 -> MemWriteOut=0, OutValid=0.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures the execute-stage result and controls,
// resolves the branch decision, and flags results that may be forwarded back to EX.
module ex_mem_reg #(
    parameter int n = 64
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         Stall,
    input  logic         Flush,
    input  logic         InValid,
    input  logic [n-1:0] ALUResult,
    input  logic         Zero,
    input  logic [n-1:0] StoreData,
    input  logic [n-1:0] BranchTarget,
    input  logic [4:0]   Rd,
    input  logic         RegWrite,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic         MemToReg,
    input  logic         Branch,
    input  logic         UncondBranch,
    output logic         OutValid,
    output logic [n-1:0] ALUResultOut,
    output logic [n-1:0] StoreDataOut,
    output logic [n-1:0] BranchTargetOut,
    output logic [4:0]   RdOut,
    output logic         RegWriteOut,
    output logic         MemReadOut,
    output logic         MemWriteOut,
    output logic         MemToRegOut,
    output logic         PCSrc,
    output logic         FwdEn
);

    logic         validReg,    validNext;
    logic [n-1:0] aluReg,      aluNext;
    logic [n-1:0] storeReg,    storeNext;
    logic [n-1:0] targetReg,   targetNext;
    logic [4:0]   rdReg,       rdNext;
    logic         regWriteReg, regWriteNext;
    logic         memReadReg,  memReadNext;
    logic         memWriteReg, memWriteNext;
    logic         memToRegReg, memToRegNext;
    logic         pcSrcReg,    pcSrcNext;

    // Reset and Flush both produce an all-zero bubble; Stall holds; otherwise capture.
    always_comb begin
        validNext    = validReg;
        aluNext      = aluReg;
        storeNext    = storeReg;
        targetNext   = targetReg;
        rdNext       = rdReg;
        regWriteNext = regWriteReg;
        memReadNext  = memReadReg;
        memWriteNext = memWriteReg;
        memToRegNext = memToRegReg;
        pcSrcNext    = pcSrcReg;
        if (Reset || Flush) begin
            validNext    = 1'b0;
            aluNext      = '0;
            storeNext    = '0;
            targetNext   = '0;
            rdNext       = 5'd0;
            regWriteNext = 1'b0;
            memReadNext  = 1'b0;
            memWriteNext = 1'b0;
            memToRegNext = 1'b0;
            pcSrcNext    = 1'b0;
        end else if (!Stall) begin
            validNext    = InValid;
            aluNext      = ALUResult;
            storeNext    = StoreData;
            targetNext   = BranchTarget;
            rdNext       = Rd;
            // Controls of a non-instruction must never reach memory or the register file.
            regWriteNext = InValid & RegWrite;
            memReadNext  = InValid & MemRead;
            memWriteNext = InValid & MemWrite;
            memToRegNext = InValid & MemToReg;
            pcSrcNext    = InValid & (UncondBranch | (Branch & Zero));
        end
    end

    always_ff @(posedge CLK) begin
        validReg    <= validNext;
        aluReg      <= aluNext;
        storeReg    <= storeNext;
        targetReg   <= targetNext;
        rdReg       <= rdNext;
        regWriteReg <= regWriteNext;
        memReadReg  <= memReadNext;
        memWriteReg <= memWriteNext;
        memToRegReg <= memToRegNext;
        pcSrcReg    <= pcSrcNext;
    end

    assign OutValid        = validReg;
    assign ALUResultOut    = aluReg;
    assign StoreDataOut    = storeReg;
    assign BranchTargetOut = targetReg;
    assign RdOut           = rdReg;
    assign RegWriteOut     = regWriteReg;
    assign MemReadOut      = memReadReg;
    assign MemWriteOut     = memWriteReg;
    assign MemToRegOut     = memToRegReg;
    assign PCSrc           = pcSrcReg;

    // Writes to XZR are still carried through but must not be forwarded.
    assign FwdEn = validReg & regWriteReg & (rdReg != 5'd31);

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed and random stimulus for ex_mem_reg; expected outputs are queued
// when each edge's inputs are driven and compared after that edge.
module tb_ex_mem_reg;

    localparam int N = 64;

    logic         CLK = 1'b0;
    logic         Reset, Stall, Flush, InValid, Zero;
    logic [N-1:0] ALUResult, StoreData, BranchTarget;
    logic [4:0]   Rd;
    logic         RegWrite, MemRead, MemWrite, MemToReg, Branch, UncondBranch;
    logic         OutValid, RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut, PCSrc, FwdEn;
    logic [N-1:0] ALUResultOut, StoreDataOut, BranchTargetOut;
    logic [4:0]   RdOut;

    ex_mem_reg #(.n(N)) dut (
        .CLK(CLK), .Reset(Reset), .Stall(Stall), .Flush(Flush), .InValid(InValid),
        .ALUResult(ALUResult), .Zero(Zero), .StoreData(StoreData),
        .BranchTarget(BranchTarget), .Rd(Rd), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .Branch(Branch),
        .UncondBranch(UncondBranch), .OutValid(OutValid), .ALUResultOut(ALUResultOut),
        .StoreDataOut(StoreDataOut), .BranchTargetOut(BranchTargetOut), .RdOut(RdOut),
        .RegWriteOut(RegWriteOut), .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
        .MemToRegOut(MemToRegOut), .PCSrc(PCSrc), .FwdEn(FwdEn)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic         rst, stall, flush, valid, zero;
        logic [N-1:0] alu, store, target;
        logic [4:0]   rd;
        logic         regw, memr, memw, m2r, br, ubr;
    } in_t;

    typedef struct {
        logic         valid;
        logic [N-1:0] alu, store, target;
        logic [4:0]   rd;
        logic         regw, memr, memw, m2r, pcsrc, fwd;
    } exp_t;

    exp_t model;
    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    function automatic in_t idle();
        in_t x;
        x = '{rst:0, stall:0, flush:0, valid:0, zero:0, alu:'0, store:'0, target:'0,
              rd:0, regw:0, memr:0, memw:0, m2r:0, br:0, ubr:0};
        return x;
    endfunction

    // Behavioural reference of one clock edge, written from the block's contract.
    function automatic exp_t predict(input exp_t cur, input in_t x);
        exp_t e;
        e = cur;
        if (x.rst || x.flush) begin
            e = '{valid:0, alu:'0, store:'0, target:'0, rd:0, regw:0, memr:0, memw:0,
                  m2r:0, pcsrc:0, fwd:0};
        end else if (!x.stall) begin
            e.valid  = x.valid;
            e.alu    = x.alu;
            e.store  = x.store;
            e.target = x.target;
            e.rd     = x.rd;
            e.regw   = x.valid && x.regw;
            e.memr   = x.valid && x.memr;
            e.memw   = x.valid && x.memw;
            e.m2r    = x.valid && x.m2r;
            e.pcsrc  = x.valid && (x.ubr || (x.br && x.zero));
        end
        e.fwd = e.valid && e.regw && (e.rd != 5'd31);
        return e;
    endfunction

    task automatic apply(input in_t x);
        Reset = x.rst; Stall = x.stall; Flush = x.flush; InValid = x.valid; Zero = x.zero;
        ALUResult = x.alu; StoreData = x.store; BranchTarget = x.target; Rd = x.rd;
        RegWrite = x.regw; MemRead = x.memr; MemWrite = x.memw; MemToReg = x.m2r;
        Branch = x.br; UncondBranch = x.ubr;
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".OutValid"},  N'(OutValid),    N'(e.valid));
        chk({tag, ".ALUResult"}, ALUResultOut,    e.alu);
        chk({tag, ".StoreData"}, StoreDataOut,    e.store);
        chk({tag, ".BrTarget"},  BranchTargetOut, e.target);
        chk({tag, ".Rd"},        N'(RdOut),       N'(e.rd));
        chk({tag, ".RegWrite"},  N'(RegWriteOut), N'(e.regw));
        chk({tag, ".MemRead"},   N'(MemReadOut),  N'(e.memr));
        chk({tag, ".MemWrite"},  N'(MemWriteOut), N'(e.memw));
        chk({tag, ".MemToReg"},  N'(MemToRegOut), N'(e.m2r));
        chk({tag, ".PCSrc"},     N'(PCSrc),       N'(e.pcsrc));
        chk({tag, ".FwdEn"},     N'(FwdEn),       N'(e.fwd));
        $display("txn %-12s valid=%0b alu=%h rd=%0d regw=%0b pcsrc=%0b fwd=%0b",
                 tag, OutValid, ALUResultOut, RdOut, RegWriteOut, PCSrc, FwdEn);
    endtask

    // Drive one edge's inputs on the falling edge, queue the prediction, check after the edge.
    task automatic step(input string tag, input in_t x);
        @(negedge CLK);
        apply(x);
        model = predict(model, x);
        sb.push_back(model);
        @(posedge CLK);
        #1;
        check_out(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_t x;
        model = '{valid:0, alu:'0, store:'0, target:'0, rd:0, regw:0, memr:0, memw:0,
                  m2r:0, pcsrc:0, fwd:0};
        apply(idle());

        // Reset with every input high
        x = '{rst:1, stall:1, flush:1, valid:1, zero:1, alu:'1, store:'1, target:'1,
              rd:5'd31, regw:1, memr:1, memw:1, m2r:1, br:1, ubr:1};
        step("reset", x);

        // Basic capture
        x = idle(); x.valid = 1; x.alu = 64'hA5; x.rd = 5; x.regw = 1; x.store = 64'h1234;
        step("capture", x);

        // Branch decisions
        x = idle(); x.valid = 1; x.br = 1; x.zero = 1; x.target = 64'h40;
        step("br_taken", x);
        x.zero = 0;
        step("br_nottaken", x);
        x = idle(); x.valid = 1; x.ubr = 1; x.target = 64'h80;
        step("ubr", x);

        // Zero glitching high between edges must not be captured
        @(negedge CLK);
        x = idle(); x.valid = 1; x.br = 1; x.target = 64'h44; x.zero = 1;
        apply(x);
        #2 Zero = 1'b0;
        x.zero = 0;
        model = predict(model, x);
        sb.push_back(model);
        @(posedge CLK);
        #1;
        check_out("zero_glitch");

        // Stall holds through new inputs, then flush wins over stall
        x = idle(); x.valid = 1; x.alu = 64'h10; x.rd = 7; x.regw = 1; x.memr = 1; x.ubr = 1;
        step("load10", x);
        x.alu = 64'h20; x.stall = 1; x.rd = 9; x.ubr = 0;
        step("stall1", x);
        step("stall2", x);
        x.flush = 1;
        step("stall_flush", x);

        // XZR destination and invalid slot
        x = idle(); x.valid = 1; x.rd = 31; x.regw = 1; x.alu = 64'hBEEF;
        step("xzr", x);
        x = idle(); x.valid = 0; x.memw = 1; x.regw = 1; x.ubr = 1; x.alu = 64'h77; x.rd = 3;
        step("invalid", x);

        // Both memory controls pass through untouched
        x = idle(); x.valid = 1; x.memr = 1; x.memw = 1; x.m2r = 1; x.rd = 2; x.regw = 1;
        step("memrw", x);

        // Reset during a stall clears, then first capture once both drop
        x.stall = 1; x.alu = 64'h55;
        step("stall_hold", x);
        x.rst = 1;
        step("rst_in_stall", x);
        x.rst = 0;
        step("stall_post", x);
        x.stall = 0;
        step("first_cap", x);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            x.rst    = ($urandom_range(0, 15) == 0);
            x.flush  = ($urandom_range(0, 7) == 0);
            x.stall  = ($urandom_range(0, 3) == 0);
            x.valid  = $urandom_range(0, 1);
            x.zero   = $urandom_range(0, 1);
            x.alu    = {$urandom, $urandom};
            x.store  = {$urandom, $urandom};
            x.target = {$urandom, $urandom};
            x.rd     = 5'($urandom);
            x.regw   = $urandom_range(0, 1);
            x.memr   = $urandom_range(0, 1);
            x.memw   = $urandom_range(0, 1);
            x.m2r    = $urandom_range(0, 1);
            x.br     = $urandom_range(0, 1);
            x.ubr    = $urandom_range(0, 1);
            step($sformatf("rand%0d", i), x);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
